// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: walks each latched instruction
// through FETCH/DECODE/... and decodes every datapath strobe from the current state.
module mips_multicycle_control #(
  parameter int HALT_FUNCT = 63,
  parameter int ALU_OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op_i,
  input  logic [5:0]          funct_i,
  input  logic                zero_i,
  output logic                iord_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic                imm_zext_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          pc_src_o,
  output logic                pc_en_o,
  output logic [3:0]          state_o,
  output logic                illegal_o,
  output logic                halted_o
);

  typedef enum logic [3:0] {
    S_FETCH        = 4'd0,
    S_DECODE       = 4'd1,
    S_MEMADDR      = 4'd2,
    S_MEMREAD      = 4'd3,
    S_MEMWRITEBACK = 4'd4,
    S_MEMWRITE     = 4'd5,
    S_EXECUTE      = 4'd6,
    S_ALUWRITEBACK = 4'd7,
    S_BRANCH       = 4'd8,
    S_IEXECUTE     = 4'd9,
    S_IWRITEBACK   = 4'd10,
    S_JUMP         = 4'd11,
    S_HALT         = 4'd12
  } mips_state_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } mips_op_e;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_LUI   = ALU_OP_W'(7);

  mips_state_e state;
  mips_state_e decode_next;
  logic        op_legal;
  logic        pc_write;
  logic        branch;

  // Unsupported opcodes (JAL, byte/half loads/stores, LL/SC, unknown) fall back to FETCH.
  always_comb begin
    decode_next = S_FETCH;
    op_legal    = 1'b1;
    case (op_i)
      OP_LW, OP_SW:   decode_next = S_MEMADDR;
      OP_RTYPE:       decode_next = (funct_i == 6'(HALT_FUNCT)) ? S_HALT : S_EXECUTE;
      OP_BEQ, OP_BNE: decode_next = S_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI: decode_next = S_IEXECUTE;
      OP_J:           decode_next = S_JUMP;
      default:        op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:        state <= S_DECODE;
        S_DECODE:       state <= decode_next;
        S_MEMADDR:      state <= (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:      state <= S_MEMWRITEBACK;
        S_EXECUTE:      state <= S_ALUWRITEBACK;
        S_IEXECUTE:     state <= S_IWRITEBACK;
        S_HALT:         state <= S_HALT;
        default:        state <= S_FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is asserted so no write can slip out.
  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    imm_zext_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    pc_src_o     = 2'b00;
    pc_write     = 1'b0;
    branch       = 1'b0;
    illegal_o    = 1'b0;
    halted_o     = 1'b0;
    state_o      = 4'd0;
    if (rst_n) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          ir_write_o  = 1'b1;
          alu_src_b_o = 2'b01;
          pc_write    = 1'b1;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          illegal_o   = !op_legal;
        end
        S_MEMADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        S_MEMREAD: iord_o = 1'b1;
        S_MEMWRITEBACK: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEMWRITE: begin
          iord_o      = 1'b1;
          mem_write_o = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        S_ALUWRITEBACK: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_src_o    = 2'b01;
          branch      = 1'b1;
        end
        S_IEXECUTE: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          case (op_i)
            OP_SLTI:  alu_op_o = ALU_SLT;
            OP_SLTIU: alu_op_o = ALU_SLTU;
            OP_ANDI: begin alu_op_o = ALU_AND; imm_zext_o = 1'b1; end
            OP_ORI:  begin alu_op_o = ALU_OR;  imm_zext_o = 1'b1; end
            OP_LUI:  begin alu_op_o = ALU_LUI; imm_zext_o = 1'b1; end
            default:  alu_op_o = ALU_ADD;
          endcase
        end
        S_IWRITEBACK: reg_write_o = 1'b1;
        S_JUMP: begin
          pc_src_o = 2'b10;
          pc_write = 1'b1;
        end
        S_HALT: halted_o = 1'b1;
        default: ;
      endcase
    end
    // BNE takes the branch when the operands differ, BEQ when they match.
    pc_en_o = pc_write | (branch & (zero_i ^ (op_i == OP_BNE)));
  end

endmodule
